// File: rtl/strobe_counter_sequencer_if.sv
// Bus bundle between the config/control side and the sequencer, plus the
// sideband to and from the pipelined counter it drives.
//   cfg_we/cfg_addr/cfg_data : period table write port
//   seq_last/loop_en/start/stop : sequence control
//   busy/done/event_strobe/event_idx : sequence status
//   cnt_rst/cnt_enable/cnt_reset_value : drive to the counter
//   cnt_strobe/cnt_ready : feedback from the counter
// master = controller / counter side, slave = sequencer.
interface strobe_counter_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic [IDX_W-1:0] seq_last;
    logic             loop_en;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic             event_strobe;
    logic [IDX_W-1:0] event_idx;
    logic             cnt_rst;
    logic             cnt_enable;
    logic [WIDTH-1:0] cnt_reset_value;
    logic             cnt_strobe;
    logic             cnt_ready;

    modport master (
        output cfg_we, cfg_addr, cfg_data, seq_last, loop_en, start, stop,
        output cnt_strobe, cnt_ready,
        input  busy, done, event_strobe, event_idx,
        input  cnt_rst, cnt_enable, cnt_reset_value
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, seq_last, loop_en, start, stop,
        input  cnt_strobe, cnt_ready,
        output busy, done, event_strobe, event_idx,
        output cnt_rst, cnt_enable, cnt_reset_value
    );
endinterface

// File: rtl/strobe_counter_sequencer.sv
// Sequencer for one pipelined strobe counter. Holds a table of DEPTH periods
// and walks the counter through slots 0..seq_last (optionally looping),
// pulsing enable only when the counter is ready and reloading reset_value
// only on the edge that ends a strobe cycle. One event per completed period.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : strobe_counter_sequencer_if.slave (config, control, status, counter)
module strobe_counter_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 16,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    strobe_counter_sequencer_if.slave    bus
);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IDX_W1 = IDX_W + 1;

    // Parameter sanity: the counter needs a nonzero pipeline, the table two slots.
    if (DEPTH < 2 || LATENCY == 0) begin : g_param_check
        $error("strobe_counter_sequencer: need DEPTH >= 2 and LATENCY > 0");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] slot_q;
    logic [IDX_W-1:0] last_q;
    logic             cnt_rst_q;
    logic             cnt_enable_q;
    logic [WIDTH-1:0] reset_value_q;
    logic             busy_q;
    logic             done_q;
    logic             event_strobe_q;
    logic [IDX_W-1:0] event_idx_q;
    logic [WIDTH-1:0] period_q [DEPTH];

    logic [IDX_W-1:0] slot_d;
    logic [IDX_W-1:0] last_clamp_c;
    logic             wr_ok_c;
    logic [WIDTH-1:0] wr_data_c;

    // Next slot wraps at the latched last slot; clamp seq_last into the table.
    always_comb begin
        slot_d       = (slot_q == last_q) ? '0 : slot_q + IDX_W'(1);
        last_clamp_c = bus.seq_last;
        if ({1'b0, bus.seq_last} >= IDX_W1'(DEPTH)) begin
            last_clamp_c = IDX_W'(DEPTH - 1);
        end
        wr_ok_c   = ({1'b0, bus.cfg_addr} < IDX_W1'(DEPTH));
        wr_data_c = (bus.cfg_data < WIDTH'(2)) ? WIDTH'(2) : bus.cfg_data;
    end

    // Period table: written at any time, never reset; periods below 2 stored as 2.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && wr_ok_c) begin
            period_q[bus.cfg_addr] <= wr_data_c;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            slot_q         <= '0;
            last_q         <= '0;
            cnt_rst_q      <= 1'b1;
            cnt_enable_q   <= 1'b0;
            reset_value_q  <= WIDTH'(2);
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            event_strobe_q <= 1'b0;
            event_idx_q    <= '0;
        end else begin
            done_q         <= 1'b0;
            event_strobe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_rst_q    <= 1'b0;
                    cnt_enable_q <= 1'b0;
                    // stop wins over a coincident start
                    if (bus.start && !bus.stop) begin
                        last_q        <= last_clamp_c;
                        slot_q        <= '0;
                        reset_value_q <= period_q[0];
                        cnt_rst_q     <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt_rst_q <= 1'b0;
                    if (bus.stop) begin
                        cnt_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        // any coincident strobe is dropped
                        cnt_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        // single-cycle pulses, only when ready was seen high
                        cnt_enable_q <= bus.cnt_ready && !cnt_enable_q;
                        if (bus.cnt_strobe) begin
                            event_strobe_q <= 1'b1;
                            event_idx_q    <= slot_q;
                            if ((slot_q == last_q) && !bus.loop_en) begin
                                state_q <= S_FIN;
                            end else begin
                                // reload on the edge ending the strobe cycle
                                slot_q        <= slot_d;
                                reset_value_q <= period_q[slot_d];
                            end
                        end
                    end
                end
                S_FIN: begin
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    cnt_enable_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_rst         = cnt_rst_q;
    assign bus.cnt_enable      = cnt_enable_q;
    assign bus.cnt_reset_value = reset_value_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.event_strobe    = event_strobe_q;
    assign bus.event_idx       = event_idx_q;
endmodule

// File: tb/tb_strobe_counter_sequencer.sv
// Bench for strobe_counter_sequencer with a behavioural pipelined counter
// (WIDTH=4, LATENCY=4), a spec-level reference model checked every cycle and
// directed scenarios with hand-computed expectations.
module tb_strobe_counter_sequencer;
    localparam int WIDTH   = 4;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strobe_counter_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    strobe_counter_sequencer #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural counter: P enable pulses per period ----------------
    int c_cnt  = 0;
    int c_pend = 0;
    initial begin
        bus.cnt_ready  = 1'b0;
        bus.cnt_strobe = 1'b0;
    end
    always @(posedge clk) begin
        if (rst || bus.cnt_rst === 1'b1) begin
            c_cnt          <= 0;
            c_pend         <= 0;
            bus.cnt_ready  <= 1'b0;
            bus.cnt_strobe <= 1'b0;
        end else begin
            bus.cnt_strobe <= 1'b0;
            if (c_pend != 0) begin
                c_pend <= c_pend - 1;
                if (c_pend == 1) bus.cnt_strobe <= 1'b1;
            end else if (bus.cnt_strobe) begin
                bus.cnt_ready <= 1'b1;
            end else if (bus.cnt_enable === 1'b1 && bus.cnt_ready) begin
                if (c_cnt + 1 >= int'(bus.cnt_reset_value)) begin
                    c_cnt         <= 0;
                    c_pend        <= LATENCY;
                    bus.cnt_ready <= 1'b0;
                end else begin
                    c_cnt <= c_cnt + 1;
                end
            end else begin
                bus.cnt_ready <= 1'b1;
            end
        end
    end

    // ---------------- reference model (sequence-level rules) ----------------
    int tbl[DEPTH] = '{default: 0};
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;   // a sequence has been accepted and not yet ended
    bit m_ending = 1'b0;   // final period reported, done pending
    int m_age    = 0;      // cycles since the accepted start
    int m_slot   = 0;
    int m_last   = 0;
    bit e_rst, e_en, e_busy, e_done, e_ev;
    int e_idx, e_rv;

    task automatic model_step();
        e_done = 1'b0;
        e_ev   = 1'b0;
        if (rst) begin
            e_rst = 1'b1; e_en = 1'b0; e_rv = 2; e_busy = 1'b0; e_idx = 0;
            m_active = 1'b0; m_ending = 1'b0; m_slot = 0;
        end else if (!m_active) begin
            e_rst = 1'b0;
            e_en  = 1'b0;
            if (bus.start && !bus.stop) begin
                m_active = 1'b1; m_ending = 1'b0; m_age = 0; m_slot = 0;
                m_last   = (int'(bus.seq_last) > DEPTH - 1) ? DEPTH - 1 : int'(bus.seq_last);
                e_rv = tbl[0]; e_rst = 1'b1; e_busy = 1'b1;
            end
        end else if (m_ending) begin
            e_done = 1'b1; e_busy = 1'b0; e_en = 1'b0; m_active = 1'b0;
        end else if (bus.stop) begin
            e_rst = 1'b0; e_en = 1'b0; e_busy = 1'b0; m_active = 1'b0;
        end else begin
            m_age++;
            e_rst = 1'b0;
            if (m_age >= 2) begin
                e_en = (bus.cnt_ready === 1'b1) && !e_en;
                if (bus.cnt_strobe === 1'b1) begin
                    e_ev  = 1'b1;
                    e_idx = m_slot;
                    if (m_slot == m_last && !bus.loop_en) begin
                        m_ending = 1'b1;
                    end else begin
                        m_slot = (m_slot + 1) % (m_last + 1);
                        e_rv   = tbl[m_slot];
                    end
                end
            end
        end
        if (bus.cfg_we && int'(bus.cfg_addr) < DEPTH)
            tbl[bus.cfg_addr] = (int'(bus.cfg_data) < 2) ? 2 : int'(bus.cfg_data);
    endtask

    // ---------------- logs of observed behaviour ----------------
    int cyc = 0;
    int en_cnt = 0;
    int ev_idx_q[$];
    int ev_rv_q[$];
    int ev_en_q[$];
    int ev_cyc_q[$];
    int done_cyc_q[$];

    task automatic clear_logs();
        ev_idx_q.delete(); ev_rv_q.delete(); ev_en_q.delete();
        ev_cyc_q.delete(); done_cyc_q.delete();
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Single compare process: check outputs against the model, log, advance model.
    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            chk("cnt_rst",         32'(bus.cnt_rst),         32'(e_rst));
            chk("cnt_enable",      32'(bus.cnt_enable),      32'(e_en));
            chk("cnt_reset_value", 32'(bus.cnt_reset_value), 32'(e_rv));
            chk("busy",            32'(bus.busy),            32'(e_busy));
            chk("done",            32'(bus.done),            32'(e_done));
            chk("event_strobe",    32'(bus.event_strobe),    32'(e_ev));
            chk("event_idx",       32'(bus.event_idx),       32'(e_idx));
            if (bus.cnt_enable === 1'b1) chk("enable_while_ready", 32'(bus.cnt_ready), 32'd1);
        end
        if (bus.event_strobe === 1'b1) begin
            ev_idx_q.push_back(int'(bus.event_idx));
            ev_rv_q.push_back(int'(bus.cnt_reset_value));
            ev_en_q.push_back(en_cnt);
            ev_cyc_q.push_back(cyc);
            en_cnt = 0;
        end
        if (bus.done === 1'b1) done_cyc_q.push_back(cyc);
        if (bus.cnt_rst === 1'b1) en_cnt = 0;
        else if (bus.cnt_enable === 1'b1) en_cnt++;
        model_step();
        m_valid = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int a, input int d);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'(a); bus.cfg_data = 4'(d);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_events(input int n, input string nm);
        int budget = 2000;
        while (ev_idx_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        if (ev_idx_q.size() < n) chk({nm, "_timeout_events"}, 32'(ev_idx_q.size()), 32'(n));
    endtask

    task automatic wait_done(input string nm);
        int budget = 2000;
        while (done_cyc_q.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (done_cyc_q.size() == 0) chk({nm, "_timeout_done"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_cnt_rst"}, 32'(bus.cnt_rst),         32'd1);
        chk({nm, "_en"},      32'(bus.cnt_enable),      32'd0);
        chk({nm, "_rv"},      32'(bus.cnt_reset_value), 32'd2);
        chk({nm, "_busy"},    32'(bus.busy),            32'd0);
        chk({nm, "_done"},    32'(bus.done),            32'd0);
        chk({nm, "_ev"},      32'(bus.event_strobe),    32'd0);
        chk({nm, "_idx"},     32'(bus.event_idx),       32'd0);
    endtask

    int exp_loop[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    int exp_per[4]   = '{3, 5, 2, 4};

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.seq_last = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_cnt_rst", 32'(bus.cnt_rst), 32'd0);

        for (int i = 0; i < 4; i++) write_slot(i, exp_per[i]);

        // One-shot sequence over the whole table.
        bus.seq_last = 2'd3; bus.loop_en = 1'b0;
        clear_logs();
        pulse_start();
        chk("t1_start_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        chk("t1_start_busy",    32'(bus.busy),    32'd1);
        wait_done("t1");
        chk("t1_events", 32'(ev_idx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_idx%0d", i),    32'(q_at(ev_idx_q, i)), 32'(i));
            chk($sformatf("t1_enables%0d", i), 32'(q_at(ev_en_q, i)), 32'(exp_per[i]));
        end
        chk("t1_done_after_last", 32'(q_at(done_cyc_q, 0)), 32'(q_at(ev_cyc_q, 3) + 1));
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        repeat (3) tick();

        // Looping sequence, ten events.
        bus.loop_en = 1'b1;
        clear_logs();
        pulse_start();
        wait_events(10, "t2");
        pulse_stop();
        for (int i = 0; i < 10; i++)
            chk($sformatf("t2_idx%0d", i), 32'(q_at(ev_idx_q, i)), 32'(exp_loop[i]));
        chk("t2_busy_after_stop", 32'(bus.busy), 32'd0);
        repeat (20) tick();

        // Period 0 is stored as 2.
        write_slot(1, 0);
        bus.seq_last = 2'd1; bus.loop_en = 1'b0;
        clear_logs();
        pulse_start();
        wait_done("t3");
        chk("t3_events", 32'(ev_idx_q.size()), 32'd2);
        chk("t3_loaded_min_period", 32'(q_at(ev_rv_q, 0)), 32'd2);
        chk("t3_enables_slot1", 32'(q_at(ev_en_q, 1)), 32'd2);
        write_slot(1, 5);
        repeat (3) tick();

        // Abort two cycles after the second event, then restart.
        bus.seq_last = 2'd3; bus.loop_en = 1'b0;
        clear_logs();
        pulse_start();
        wait_events(2, "t4");
        tick();
        pulse_stop();
        chk("t4_busy_after_stop", 32'(bus.busy),       32'd0);
        chk("t4_en_after_stop",   32'(bus.cnt_enable), 32'd0);
        repeat (40) tick();
        chk("t4_no_more_events", 32'(ev_idx_q.size()),   32'd2);
        chk("t4_no_done",        32'(done_cyc_q.size()), 32'd0);
        clear_logs();
        pulse_start();
        chk("t4_restart_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        tick();
        chk("t4_cnt_rst_one_cycle", 32'(bus.cnt_rst), 32'd0);
        wait_done("t4b");
        chk("t4_restart_first_idx", 32'(q_at(ev_idx_q, 0)), 32'd0);
        repeat (3) tick();

        // Reset mid-run, with a start in the same cycle.
        bus.loop_en = 1'b1;
        clear_logs();
        pulse_start();
        wait_events(1, "t5");
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        chk_reset_outputs("t5_rst");
        repeat (10) tick();
        chk("t5_busy_stays_low", 32'(bus.busy), 32'd0);
        chk("t5_no_events",      32'(ev_idx_q.size()), 32'd1);
        chk("t5_no_done",        32'(done_cyc_q.size()), 32'd0);

        // start && stop in IDLE: stop wins.
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t6_ss_busy",    32'(bus.busy),    32'd0);
        chk("t6_ss_cnt_rst", 32'(bus.cnt_rst), 32'd0);
        tick();
        chk("t6_ss_busy2", 32'(bus.busy), 32'd0);

        // Rewrite slot 2 while it is the active period.
        bus.seq_last = 2'd3; bus.loop_en = 1'b1;
        clear_logs();
        pulse_start();
        wait_events(2, "t6");
        write_slot(2, 6);
        chk("t6_rv_unchanged", 32'(bus.cnt_reset_value), 32'd2);
        wait_events(7, "t6b");
        pulse_stop();
        chk("t6_old_reload",  32'(q_at(ev_rv_q, 1)), 32'd2);
        chk("t6_old_period",  32'(q_at(ev_en_q, 2)), 32'd2);
        chk("t6_new_reload",  32'(q_at(ev_rv_q, 5)), 32'd6);
        chk("t6_new_period",  32'(q_at(ev_en_q, 6)), 32'd6);
        chk("t6_idx6",        32'(q_at(ev_idx_q, 6)), 32'd2);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
